tx_arbiter: RTL and testbench
=============================

Name: tx_arbiter

Overview:
- Schedules and shares the USB transmit path (tx_packet/tx_done interface of the TX FSM) between two requesters.
- Requester 1 is the handshake source: the RX protocol controller needs ACK/NACK replies.
- Requester 2 is the data source: the endpoint buffer side needs DATA packets.
- Issues one packet command at a time, waits for completion, enforces an inter-packet gap, guards against a hung transmitter with a watchdog, and prevents data starvation.

Parameters:
- GAP_CYCLES, 16: idle clocks after each completed or aborted packet before the next grant; 0 means no gap.
- TIMEOUT_CYCLES, 4096: maximum clocks in WAIT_DONE before abort.
- HS_STREAK_MAX, 4: consecutive handshake grants allowed while data_req is pending before data is forced to win.

Ports:
- clk  in  1  system clock
- n_rst  in  1  reset, asynchronous, active-low
- hs_req  in  1  handshake request level; held until hs_ack
- hs_nack  in  1  handshake type, sampled at grant: 0=ACK, 1=NACK
- data_req  in  1  data packet request level; held until data_ack
- data_size  in  7  payload byte count, sampled at grant
- tx_done  in  1  single-cycle completion pulse from TX FSM
- tx_packet  out  2  packet command strobe: 00 none, 01 DATA, 10 ACK, 11 NACK
- tx_size  out  7  payload size for current packet
- hs_ack  out  1  one-cycle pulse: handshake packet finished or aborted
- data_ack  out  1  one-cycle pulse: data packet finished or aborted
- busy  out  1  high in every state except IDLE
- tx_error  out  1  one-cycle pulse on watchdog timeout

Behaviour:
- Reset (async, any state, mid-packet included): state IDLE; outputs tx_packet=00, tx_size=0, hs_ack=0, data_ack=0, busy=0, tx_error=0; counters and streak cleared; owner cleared.
- All outputs are registered.
- IDLE:
  - Sample requests each cycle.
  - If either request is high, arbitrate and go to ISSUE on the next edge.
  - Latch owner, packet code and tx_size at that edge: data grant gives tx_size=data_size; handshake grant gives tx_size=0.
- Arbitration:
  - Handshake wins by default.
  - Data wins if data_req=1, hs_req=1 and streak==HS_STREAK_MAX.
  - Streak increments on each handshake grant while data_req=1.
  - Streak clears on a data grant, or in any IDLE cycle with data_req=0.
  - Streak saturates at HS_STREAK_MAX.
- ISSUE (exactly 1 cycle): tx_packet = latched code (01/10/11); next state WAIT_DONE. tx_packet is 00 in every other state, so it is a one-cycle strobe. Latency from request-high in IDLE to strobe is 2 clocks.
- WAIT_DONE:
  - The watchdog counter counts up from 0.
  - On tx_done=1: pulse the owner's ack next cycle, go to GAP.
  - If the counter reaches TIMEOUT_CYCLES-1 without tx_done: pulse tx_error and the owner's ack in the same cycle, go to GAP.
  - If tx_done and timeout coincide, tx_done wins and there is no error.
- GAP:
  - Count GAP_CYCLES clocks, then return to IDLE.
  - If GAP_CYCLES=0, go directly from ack to IDLE.
  - Requests are ignored in GAP.
  - tx_done pulses received outside WAIT_DONE are ignored.
- Requesters must deassert req the cycle after ack. A req still high on return to IDLE is treated as a new request.
- hs_nack and data_size are don't-care when the matching req is low.
- tx_size holds its value until the next grant.

Decomposition:
- Package usb_tx_pkg:
  - enum tx_cmd_t {TX_NONE=2'b00, TX_DATA=2'b01, TX_ACK=2'b10, TX_NACK=2'b11}
  - enum arb_state_t {IDLE, ISSUE, WAIT_DONE, GAP}
  - enum owner_t {OWN_NONE, OWN_HS, OWN_DATA}
- Sub-module tx_interval_timer: a loadable up-counter with clear, enable and terminal-value compare. It is shared for the gap and the watchdog (only one is active per state). The counter width is sized from the larger of GAP_CYCLES and TIMEOUT_CYCLES.

Test Plan:
- Lone data request: data_req=1, data_size=7'd12.
  - tx_packet=01 for 1 cycle, 2 clocks after the request; tx_size=12.
  - tx_done pulse → data_ack pulses 1 cycle later.
  - busy drops exactly 16 clocks after that.
- Simultaneous hs_req=1 (hs_nack=1) and data_req=1 at streak 0 → NACK (11) issued first; data issued after its tx_done plus the gap.
- Starvation: hs_req held continuously with data_req=1.
  - Four ACK (10) grants, then the fifth grant is DATA (01).
  - Streak returns to 0 afterwards.
- Watchdog: DATA issued and tx_done never asserted → tx_error and data_ack pulse together at clock 4095 of WAIT_DONE, then the gap, then IDLE.
- Coincidence and stray pulses:
  - tx_done arrives on the timeout cycle → no tx_error.
  - A stray tx_done during GAP or IDLE → no ack and no state change.
- Reset mid-WAIT_DONE: n_rst low for 1 cycle → all outputs 0 immediately; no ack is emitted after release; a held data_req is re-granted from IDLE.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// Shared types for the USB transmit arbiter.
// Packet command codes, arbiter states and owner tags.
package usb_tx_pkg;

    typedef enum logic [1:0] {
        TX_NONE = 2'b00,
        TX_DATA = 2'b01,
        TX_ACK  = 2'b10,
        TX_NACK = 2'b11
    } tx_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        GAP
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_HS,
        OWN_DATA
    } owner_t;

    // Counter width able to hold the larger of two terminal counts.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/tx_interval_timer.sv
// Up-counter with clear, enable and terminal-value compare.
// Shared between the inter-packet gap and the transmit watchdog.
module tx_interval_timer #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] term_i,
    output logic         hit_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign hit_o = (cnt_q == term_i);

endmodule

// File: rtl/tx_arbiter.sv
// Shares the USB TX FSM between handshake and data requesters,
// with inter-packet gap, watchdog and data anti-starvation.
module tx_arbiter
    import usb_tx_pkg::*;
#(
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int HS_STREAK_MAX  = 4
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       hs_req,
    input  logic       hs_nack,
    input  logic       data_req,
    input  logic [6:0] data_size,
    input  logic       tx_done,
    output logic [1:0] tx_packet,
    output logic [6:0] tx_size,
    output logic       hs_ack,
    output logic       data_ack,
    output logic       busy,
    output logic       tx_error
);

    localparam int CW = cnt_width(GAP_CYCLES, TIMEOUT_CYCLES);
    localparam int SW = $clog2(HS_STREAK_MAX + 1);
    localparam logic [CW-1:0] TO_TERM  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_TERM =
        CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [SW-1:0] STREAK_MAX = SW'(HS_STREAK_MAX);

    arb_state_t    state_q, state_d;
    owner_t        owner_q, owner_d;
    tx_cmd_t       cmd_q, cmd_d;
    tx_cmd_t       pkt_q, pkt_d;
    logic [6:0]    size_q, size_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          hs_ack_q, hs_ack_d;
    logic          data_ack_q, data_ack_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;

    logic          data_win;
    logic          tmr_clr;
    logic          tmr_en;
    logic          tmr_hit;
    logic [CW-1:0] tmr_term;

    tx_interval_timer #(
        .W(CW)
    ) u_timer (
        .clk   (clk),
        .n_rst (n_rst),
        .clr_i (tmr_clr),
        .en_i  (tmr_en),
        .term_i(tmr_term),
        .hit_o (tmr_hit)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        cmd_d      = cmd_q;
        size_d     = size_q;
        streak_d   = streak_q;
        pkt_d      = TX_NONE;
        hs_ack_d   = 1'b0;
        data_ack_d = 1'b0;
        err_d      = 1'b0;
        tmr_clr    = 1'b0;
        tmr_en     = 1'b0;
        tmr_term   = TO_TERM;
        data_win   = data_req && (!hs_req || streak_q == STREAK_MAX);

        case (state_q)
            IDLE: begin
                tmr_clr = 1'b1;
                if (!data_req) streak_d = '0;
                if (hs_req || data_req) begin
                    state_d = ISSUE;
                    if (data_win) begin
                        owner_d  = OWN_DATA;
                        cmd_d    = TX_DATA;
                        size_d   = data_size;
                        streak_d = '0;
                    end else begin
                        owner_d = OWN_HS;
                        cmd_d   = hs_nack ? TX_NACK : TX_ACK;
                        size_d  = '0;
                        if (data_req && streak_q != STREAK_MAX)
                            streak_d = streak_q + 1'b1;
                    end
                end
            end
            ISSUE: begin
                pkt_d   = cmd_q;
                tmr_clr = 1'b1;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                tmr_en = 1'b1;
                // A completion on the timeout cycle is a success.
                if (tx_done || tmr_hit) begin
                    hs_ack_d   = (owner_q == OWN_HS);
                    data_ack_d = (owner_q == OWN_DATA);
                    err_d      = !tx_done;
                    tmr_clr    = 1'b1;
                    state_d    = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                tmr_en   = 1'b1;
                tmr_term = GAP_TERM;
                if (tmr_hit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_NONE;
            cmd_q      <= TX_NONE;
            pkt_q      <= TX_NONE;
            size_q     <= '0;
            streak_q   <= '0;
            hs_ack_q   <= 1'b0;
            data_ack_q <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            cmd_q      <= cmd_d;
            pkt_q      <= pkt_d;
            size_q     <= size_d;
            streak_q   <= streak_d;
            hs_ack_q   <= hs_ack_d;
            data_ack_q <= data_ack_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_packet = pkt_q;
    assign tx_size   = size_q;
    assign hs_ack    = hs_ack_q;
    assign data_ack  = data_ack_q;
    assign busy      = busy_q;
    assign tx_error  = err_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter: timestamp-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_tx_arbiter;

    localparam int GAP = 16;
    localparam int TMO = 4096;
    localparam int HSM = 4;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       hs_req = 1'b0;
    logic       hs_nack = 1'b0;
    logic       data_req = 1'b0;
    logic [6:0] data_size = 7'd0;
    logic       tx_done = 1'b0;
    logic [1:0] tx_packet;
    logic [6:0] tx_size;
    logic       hs_ack;
    logic       data_ack;
    logic       busy;
    logic       tx_error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tx_arbiter #(
        .GAP_CYCLES    (GAP),
        .TIMEOUT_CYCLES(TMO),
        .HS_STREAK_MAX (HSM)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .hs_req   (hs_req),
        .hs_nack  (hs_nack),
        .data_req (data_req),
        .data_size(data_size),
        .tx_done  (tx_done),
        .tx_packet(tx_packet),
        .tx_size  (tx_size),
        .hs_ack   (hs_ack),
        .data_ack (data_ack),
        .busy     (busy),
        .tx_error (tx_error)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: ages measured in clock edges since the grant.
    logic [1:0] e_pkt = 2'd0;
    logic [6:0] e_size = 7'd0;
    logic       e_hs = 1'b0;
    logic       e_da = 1'b0;
    logic       e_busy = 1'b0;
    logic       e_err = 1'b0;

    initial begin
        bit m_busy, m_done, m_data, dwin;
        int m_age, m_gap, m_streak;
        logic [1:0] m_code;
        m_busy = 0; m_done = 0; m_data = 0;
        m_age = 0; m_gap = 0; m_streak = 0; m_code = 0;
        forever begin
            @(posedge clk or negedge n_rst);
            if (!n_rst) begin
                m_busy = 0; m_done = 0; m_streak = 0;
                e_pkt = 0; e_size = 0; e_hs = 0;
                e_da = 0; e_busy = 0; e_err = 0;
            end else begin
                e_pkt = 0; e_hs = 0; e_da = 0; e_err = 0;
                if (!m_busy) begin
                    if (!data_req) m_streak = 0;
                    if (hs_req || data_req) begin
                        dwin = data_req &&
                               (!hs_req || m_streak == HSM);
                        m_busy = 1; m_age = 0; m_done = 0;
                        m_data = dwin;
                        if (dwin) begin
                            m_code = 2'b01;
                            e_size = data_size;
                            m_streak = 0;
                        end else begin
                            m_code = hs_nack ? 2'b11 : 2'b10;
                            e_size = 0;
                            if (data_req && m_streak < HSM)
                                m_streak++;
                        end
                    end
                end else begin
                    m_age++;
                    if (m_age == 1) begin
                        e_pkt = m_code;
                    end else if (!m_done) begin
                        if (tx_done || m_age == 1 + TMO) begin
                            e_hs = !m_data;
                            e_da = m_data;
                            e_err = !tx_done;
                            m_done = 1;
                            m_gap = 0;
                            if (GAP == 0) m_busy = 0;
                        end
                    end else begin
                        m_gap++;
                        if (m_gap == GAP) m_busy = 0;
                    end
                end
                e_busy = m_busy;
            end
        end
    end

    always @(negedge clk)
        chk("cycle",
            int'({tx_packet, tx_size, hs_ack, data_ack, busy, tx_error}),
            int'({e_pkt, e_size, e_hs, e_da, e_busy, e_err}));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // sel: 0 strobe, 1 any ack, 2 idle, 3 tx_error
    task automatic wait_on(input int sel, input string nm,
                           input int lim, output int n);
        bit hit;
        n = 0;
        hit = 0;
        while (!hit && n < lim) begin
            tick();
            n++;
            case (sel)
                0: hit = (tx_packet != 2'b00);
                1: hit = hs_ack | data_ack;
                2: hit = !busy;
                default: hit = tx_error;
            endcase
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL %s: no event within %0d cycles", nm, n);
        end
    endtask

    initial begin
        int n;

        #12;
        chk("reset_outputs",
            int'({tx_packet, tx_size, hs_ack, data_ack, busy, tx_error}), 0);
        @(posedge clk);
        #1 n_rst = 1'b1;
        tick();

        // Lone data request
        data_req = 1'b1;
        data_size = 7'd12;
        wait_on(0, "lone_strobe", 50, n);
        chk("lone_latency", n, 2);
        chk("lone_code", int'(tx_packet), 1);
        chk("lone_size", int'(tx_size), 12);
        tick();
        chk("lone_strobe_len", int'(tx_packet), 0);
        tick(); tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("lone_ack", int'({hs_ack, data_ack}), 1);
        data_req = 1'b0;
        wait_on(2, "lone_idle", 50, n);
        chk("lone_gap", n, 16);

        // Simultaneous requests: NACK first, then data after the gap
        hs_req = 1'b1; hs_nack = 1'b1;
        data_req = 1'b1; data_size = 7'd40;
        wait_on(0, "sim_strobe1", 50, n);
        chk("sim_first", int'(tx_packet), 3);
        chk("sim_first_size", int'(tx_size), 0);
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("sim_hs_ack", int'({hs_ack, data_ack}), 2);
        hs_req = 1'b0;
        wait_on(0, "sim_strobe2", 50, n);
        chk("sim_second_delay", n, 18);
        chk("sim_second", int'(tx_packet), 1);
        chk("sim_second_size", int'(tx_size), 40);
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        data_req = 1'b0;
        wait_on(2, "sim_idle", 50, n);

        // Starvation guard with both requests held
        hs_req = 1'b1; hs_nack = 1'b0;
        data_req = 1'b1; data_size = 7'd33;
        for (int g = 0; g < 10; g++) begin
            wait_on(0, "starve_strobe", 100, n);
            chk($sformatf("starve_grant%0d", g), int'(tx_packet),
                (g % 5 == 4) ? 1 : 2);
            tick(); tick();
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            chk($sformatf("starve_ack%0d", g), int'({hs_ack, data_ack}),
                (g % 5 == 4) ? 1 : 2);
        end
        hs_req = 1'b0;
        data_req = 1'b0;
        wait_on(2, "starve_idle", 50, n);

        // Watchdog
        data_req = 1'b1; data_size = 7'd5;
        wait_on(0, "wd_strobe", 50, n);
        wait_on(3, "wd_error", 5000, n);
        chk("wd_delay", n, 4096);
        chk("wd_ack", int'({hs_ack, data_ack}), 1);
        data_req = 1'b0;
        tick();
        chk("wd_err_pulse", int'(tx_error), 0);
        wait_on(2, "wd_idle", 50, n);
        chk("wd_gap", n, 15);

        // tx_done on the timeout cycle wins
        data_req = 1'b1; data_size = 7'd7;
        wait_on(0, "co_strobe", 50, n);
        repeat (4095) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("co_ack", int'({hs_ack, data_ack}), 1);
        chk("co_no_err", int'(tx_error), 0);
        data_req = 1'b0;

        // Stray tx_done in GAP and in IDLE
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("stray_gap", int'({hs_ack, data_ack, busy}), 1);
        wait_on(2, "stray_idle", 50, n);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick();
        chk("stray_idle", int'({hs_ack, data_ack, busy, tx_packet}), 0);

        // Reset during WAIT_DONE
        data_req = 1'b1; data_size = 7'd9;
        wait_on(0, "rst_strobe", 50, n);
        repeat (3) tick();
        #3 n_rst = 1'b0;
        #1;
        chk("rst_async",
            int'({tx_packet, tx_size, hs_ack, data_ack, busy, tx_error}), 0);
        @(posedge clk);
        #1 n_rst = 1'b1;
        chk("rst_no_ack", int'({hs_ack, data_ack}), 0);
        wait_on(0, "rst_regrant", 50, n);
        chk("rst_regrant_delay", n, 2);
        chk("rst_regrant_code", int'(tx_packet), 1);
        chk("rst_regrant_size", int'(tx_size), 9);
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("rst_final_ack", int'({hs_ack, data_ack}), 1);
        data_req = 1'b0;
        wait_on(2, "rst_idle", 50, n);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
